// File: rtl/aes_subbytes_shiftrows.sv
// AES SubBytes (+ optional ShiftRows) over a 128-bit state, using one shared S-box
// one byte per cycle: accept in IDLE, 16 BUSY cycles, hold result in DONE until taken.

module aes_sbox (
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  // Byte i of the table sits at bits [8*(255-i) +: 8]; 255-i is simply ~i.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_out = SBOX_TABLE[{~data_in, 3'b000} +: 8];
endmodule

module aes_subbytes_shiftrows #(
  parameter int SHIFT_ROWS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [1:0]   dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid here are pure decodes of the state register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] src;
  logic [127:0] result;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [1:0]   dst_col;
  logic [3:0]   dst;

  aes_sbox u_sbox (
    .data_in  (sbox_in),
    .data_out (sbox_out)
  );

  // Byte index b = r + 4c, i.e. {c, r}; ShiftRows moves (r,c) to (r,(c-r) mod 4).
  assign sbox_in = src[{~cnt, 3'b000} +: 8];
  assign dst_col = cnt[3:2] - cnt[1:0];
  assign dst     = (SHIFT_ROWS != 0) ? {dst_col, cnt[1:0]} : cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      result <= 128'h0;
    end else begin
      case (state)
        IDLE: if (in_valid) cnt <= 4'd0;
        BUSY: begin
          cnt                          <= cnt + 4'd1;
          result[{~dst, 3'b000} +: 8]  <= sbox_out;
        end
        default: ;
      endcase
    end
  end

  // Source register deliberately has no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) src <= in_state;
  end

  assign out_state = result;
  assign dbg_state = state;
endmodule

// File: tb/tb_aes_subbytes_shiftrows.sv
// Bench for aes_subbytes_shiftrows: two instances (with and without ShiftRows) driven
// in lockstep, checked against FIPS-197 vectors and a GF(2^8)-derived S-box model.

module tb_aes_subbytes_shiftrows;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;

  logic         in_ready_sr, out_valid_sr, in_ready_ns, out_valid_ns;
  logic [127:0] out_state_sr, out_state_ns;
  logic [1:0]   dbg_sr, dbg_ns;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_q[$];
  logic [127:0] exp_ns_q[$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_53   = {16{8'h53}};
  localparam logic [127:0] ALL_ED   = {16{8'hed}};

  aes_subbytes_shiftrows #(.SHIFT_ROWS(1)) dut_sr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sr),
    .in_state(in_state), .out_valid(out_valid_sr), .out_ready(out_ready),
    .out_state(out_state_sr), .dbg_state(dbg_sr)
  );

  aes_subbytes_shiftrows #(.SHIFT_ROWS(0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ns),
    .in_state(in_state), .out_valid(out_valid_ns), .out_ready(out_ready),
    .out_state(out_state_ns), .dbg_state(dbg_ns)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Reference model: S-box built from field inversion plus the affine map
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x, s;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[v] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input bit sr);
    logic [127:0] o;
    int r, c, sb;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      r  = b % 4;
      c  = b / 4;
      sb = sr ? (r + 4 * ((c + r) % 4)) : b;
      o[127 - 8*b -: 8] = sbox_tab[s[127 - 8*sb -: 8]];
    end
    return o;
  endfunction

  // Driver tasks (all stimulus applied 1 time unit after a rising edge)
  task automatic send(input logic [127:0] v);
    in_state = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid_sr && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready_sr !== 1'b1 || out_valid_sr !== 1'b0 || out_state_sr !== 128'h0 || dbg_sr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sr: rdy=%b vld=%b st=%h dbg=%0d, required rdy=1 vld=0 st=0 dbg=0",
               in_ready_sr, out_valid_sr, out_state_sr, dbg_sr);
    end
    n_checks++;
    if (in_ready_ns !== 1'b1 || out_valid_ns !== 1'b0 || out_state_ns !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_ns: rdy=%b vld=%b st=%h, required rdy=1 vld=0 st=0",
               in_ready_ns, out_valid_ns, out_state_ns);
    end
  endtask

  task automatic test_fips_vector();
    int cyc;
    send(FIPS_IN);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 16 || out_valid_ns !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_latency: %0d cycles (ns valid=%b), required 16 cycles", cyc, out_valid_ns);
    end
    n_checks++;
    if (out_state_sr !== FIPS_SR) begin
      n_fail++;
      $display("FAIL fips_shiftrows: got %h, required %h", out_state_sr, FIPS_SR);
    end
    n_checks++;
    if (out_state_ns !== FIPS_SB) begin
      n_fail++;
      $display("FAIL fips_subbytes: got %h, required %h", out_state_ns, FIPS_SB);
    end
    release_out();
    n_checks++;
    if (in_ready_sr !== 1'b1 || out_valid_sr !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready_sr, out_valid_sr);
    end
  endtask

  task automatic test_constants();
    int cyc;
    logic [127:0] ins  [2];
    logic [127:0] exps [2];
    ins[0] = 128'h0; exps[0] = ALL_63;
    ins[1] = ALL_53; exps[1] = ALL_ED;
    for (int k = 0; k < 2; k++) begin
      send(ins[k]);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 16 || out_state_sr !== exps[k] || out_state_ns !== exps[k]) begin
        n_fail++;
        $display("FAIL const_%0d: cyc=%0d sr=%h ns=%h, required cyc=16 both=%h",
                 k, cyc, out_state_sr, out_state_ns, exps[k]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [127:0] held;
    logic [127:0] nxt;
    held = 128'h00112233445566778899aabbccddeeff;
    nxt  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    send(held);
    wait_done(cyc);
    n_checks++;
    if (out_state_sr !== model(held, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_result: got %h, required %h", out_state_sr, model(held, 1'b1));
    end
    in_state = nxt;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_sr !== 1'b1 || in_ready_sr !== 1'b0 || out_state_sr !== model(held, 1'b1)) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b st=%h, required vld=1 rdy=0 st=%h",
                 i, out_valid_sr, in_ready_sr, out_state_sr, model(held, 1'b1));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready_sr !== 1'b1 || out_valid_sr !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_to_idle: rdy=%b vld=%b, required rdy=1 vld=0", in_ready_sr, out_valid_sr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc !== 16 || out_state_sr !== model(nxt, 1'b1) || out_state_ns !== model(nxt, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_next: cyc=%0d sr=%h ns=%h, required cyc=16 sr=%h ns=%h",
               cyc, out_state_sr, out_state_ns, model(nxt, 1'b1), model(nxt, 1'b0));
    end
    release_out();
  endtask

  task automatic test_reset_midop();
    int cyc;
    send(128'hdeadbeefcafef00d0123456789abcdef);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready_sr !== 1'b1 || out_valid_sr !== 1'b0 || out_state_sr !== 128'h0 ||
        out_state_ns !== 128'h0 || dbg_sr !== 2'd0) begin
      n_fail++;
      $display("FAIL midop_reset: rdy=%b vld=%b sr=%h ns=%h dbg=%0d, required rdy=1 vld=0 st=0 dbg=0",
               in_ready_sr, out_valid_sr, out_state_sr, out_state_ns, dbg_sr);
    end
    send(FIPS_IN);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 16 || out_state_sr !== FIPS_SR || out_state_ns !== FIPS_SB) begin
      n_fail++;
      $display("FAIL midop_after: cyc=%0d sr=%h ns=%h, required cyc=16 sr=%h ns=%h",
               cyc, out_state_sr, out_state_ns, FIPS_SR, FIPS_SB);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] v, e_sr, e_ns;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      v = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model(v, 1'b1));
      exp_ns_q.push_back(model(v, 1'b0));
      send(v);
      wait_done(cyc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      e_sr = exp_q.pop_front();
      e_ns = exp_ns_q.pop_front();
      n_checks++;
      if (cyc !== 16 || out_valid_sr !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d_latency: cyc=%0d vld=%b, required cyc=16 vld=1", i, cyc, out_valid_sr);
      end
      n_checks++;
      if (out_state_sr !== e_sr || out_state_ns !== e_ns) begin
        n_fail++;
        $display("FAIL stream_%0d_data: sr=%h ns=%h, required sr=%h ns=%h",
                 i, out_state_sr, out_state_ns, e_sr, e_ns);
      end
      release_out();
      n_checks++;
      if (out_valid_sr !== 1'b0 || out_valid_ns !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_%0d_dup: vld sr=%b ns=%b, required 0", i, out_valid_sr, out_valid_ns);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_leftover: %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_constants();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_subbytes_shiftrows.md
AES_SUBBYTES_SHIFTROWS -- requirements
Module: aes_subbytes_shiftrows

Interface
REQ-001 Parameter SHIFT_ROWS, default 1: 1 applies ShiftRows after SubBytes; 0 outputs SubBytes only.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_state is valid this cycle.
REQ-005 in_ready  output  1  block can accept a new state this cycle.
REQ-006 in_state  input  128  AES state; byte b = in_state[127-8b -: 8], b = r + 4c (column-major: row r, column c).
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  consumer accepts out_state this cycle.
REQ-009 out_state  output  128  transformed state, same byte ordering as in_state.

Function
REQ-010 The block SHALL contain exactly one aes_sbox instance (8-bit data_in, 8-bit combinational data_out) and SHALL serialise all 16 substitutions through it, one byte per cycle.
REQ-011 FSM states SHALL be IDLE, BUSY and DONE; 2-bit state register.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational path from in_valid/out_ready.
REQ-013 IDLE: on in_valid=1, the block SHALL capture in_state into the source register, clear the 4-bit byte counter to 0 and go to BUSY; otherwise stay in IDLE.
REQ-014 BUSY: each cycle, sbox data_in SHALL be source byte[counter], and data_out SHALL be written to result byte position dst(counter).
REQ-015 dst(b) = b when SHIFT_ROWS=0; when SHIFT_ROWS=1, source byte (r,c) SHALL be written to position (r,(c-r) mod 4), i.e. out(r,c) = in(r,(c+r) mod 4).
REQ-016 Counter SHALL increment by 1 each BUSY cycle; on the cycle counter=15, the last byte SHALL be written and the FSM SHALL go to DONE. There is no wrap within one operation.
REQ-017 Latency: with the handshake accepted on edge T, out_valid SHALL first be 1 after edge T+16 (16 BUSY cycles).
REQ-018 DONE: out_state and out_valid SHALL hold stable until out_ready=1; on out_ready=1 the FSM SHALL go to IDLE at that edge.
REQ-019 in_valid in BUSY or DONE SHALL be ignored (in_ready=0); the source register is not modified.
REQ-020 out_ready in IDLE or BUSY SHALL have no effect.
REQ-021 Throughput: one state per 18 cycles maximum (accept, 16 BUSY, DONE with out_ready=1); no back-to-back overlap.
REQ-022 out_state SHALL be driven directly from the result register; its contents outside DONE are don't-care, but it SHALL not change while in DONE.

Reset
REQ-023 With rst=1 at a rising edge, FSM SHALL go to IDLE, counter to 0, result register to 128'h0; hence in_ready=1, out_valid=0, out_state=0 after that edge.
REQ-024 rst SHALL take priority over all other inputs in every state; an operation in BUSY or DONE SHALL be abandoned with no output produced.
REQ-025 Source register contents are not reset (don't-care until the next capture).

Verification
REQ-026 SHIFT_ROWS=1, in_state=193de3bea0f4e22b9ac68d2ae9f84808 accepted -> out_valid rises exactly 16 cycles later with out_state=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-027 SHIFT_ROWS=0, same input -> out_state=d42711aee0bf98f1b8b45de51e415230 at the same latency.
REQ-028 in_state=128'h0 -> out_state=636363...63 (all 16 bytes 8'h63) for either parameter value; in_state=all 8'h53 -> all 8'hed.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new value -> out_state and out_valid stay stable, in_ready=0, new value not captured; out_ready=1 -> IDLE next cycle, then the new value is accepted.
REQ-030 Assert rst for one cycle at BUSY counter=7 -> next cycle in_ready=1, out_valid=0, out_state=0; a subsequent operation produces the correct result with full 16-cycle latency.
REQ-031 Random streams of 1000 states with random in_valid/out_ready gaps -> every output matches a software SubBytes/ShiftRows model, and none are dropped or duplicated.
